// File: rtl/dp_fifo_ctrl.sv
// dp_fifo_ctrl: single-clock FIFO controller for a 16x4 dual-port EBR RAM.
// Turns push/pop requests into RAM write/read strobes and addresses, tracks
// occupancy, and optionally generates/checks even parity on the RAM EDI/EDO lane.
//
// Optional feature macro: DP_FIFO_PARITY_EN
//   defined   -> RamEDI carries even parity of Data; ParityErr flags EDO mismatch
//   undefined -> RamEDI = 0, RamEDO ignored, ParityErr = 0
//
// Ports:
//   Clock, ResetN         clock and asynchronous active-low reset
//   Data, WrReq, RdReq    push data, push request, pop request
//   Q, QValid, ParityErr  pop data (one cycle after accepted pop), valid, parity error
//   Empty, Full           occupancy flags (registered-state decodes)
//   Overflow, Underflow   one-cycle pulse after a rejected push / pop
//   RamData, RamWrAddress, RamWrEn, RamEDI   RAM write port
//   RamRdAddress, RamRdEn                    RAM read port
//   RamQ, RamEDO                             RAM registered read data / parity
module dp_fifo_ctrl #(
  parameter int unsigned lpm_width        = 4,
  parameter int unsigned lpm_widthad      = 4,
  parameter int unsigned lpm_parity_width = 1
) (
  input  logic                        Clock,
  input  logic                        ResetN,
  input  logic [lpm_width-1:0]        Data,
  input  logic                        WrReq,
  input  logic                        RdReq,
  output logic [lpm_width-1:0]        Q,
  output logic                        QValid,
  output logic                        ParityErr,
  output logic                        Empty,
  output logic                        Full,
  output logic                        Overflow,
  output logic                        Underflow,
  output logic [lpm_width-1:0]        RamData,
  output logic [lpm_widthad-1:0]      RamWrAddress,
  output logic [lpm_widthad-1:0]      RamRdAddress,
  output logic                        RamWrEn,
  output logic                        RamRdEn,
  output logic [lpm_parity_width-1:0] RamEDI,
  input  logic [lpm_width-1:0]        RamQ,
  input  logic [lpm_parity_width-1:0] RamEDO
);

  localparam int unsigned CNT_W = lpm_widthad + 1;
  localparam int unsigned DEPTH = 2 ** lpm_widthad;

  logic [lpm_widthad-1:0] wr_ptr;
  logic [lpm_widthad-1:0] rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   rd_pend;
  logic                   push_ok;
  logic                   pop_ok;

  // Flags decode registered count only; accepts follow from them.
  always_comb begin
    Empty   = (count == '0);
    Full    = (count == CNT_W'(DEPTH));
    push_ok = WrReq & ~Full;
    pop_ok  = RdReq & ~Empty;
  end

  // RAM port drive: strobes are the accept terms themselves.
  always_comb begin
    RamWrEn      = push_ok;
    RamWrAddress = wr_ptr;
    RamData      = Data;
    RamRdEn      = pop_ok;
    RamRdAddress = rd_ptr;
  end

  // Pointers, occupancy, read-pending and error pulses.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + lpm_widthad'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + lpm_widthad'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      rd_pend   <= pop_ok;
      Overflow  <= WrReq & Full;
      Underflow <= RdReq & Empty;
    end
  end

  // Read data comes straight from the RAM's registered output.
  assign Q      = RamQ;
  assign QValid = rd_pend;

`ifdef DP_FIFO_PARITY_EN
  // Even parity on lane bit 0; upper lane bits (if any) zero-extended.
  assign RamEDI    = lpm_parity_width'(^Data);
  assign ParityErr = rd_pend & ((^RamQ) != RamEDO[0]);
`else
  logic unused_edo;
  assign unused_edo = ^RamEDO;
  assign RamEDI     = '0;
  assign ParityErr  = 1'b0;
`endif

endmodule

// File: tb/tb_dp_fifo_ctrl.sv
// Directed self-checking bench for dp_fifo_ctrl with a behavioural 16x4 RAM
// (registered read, EDI/EDO lane, injectable EDO inversion).
module tb_dp_fifo_ctrl;

`ifdef DP_FIFO_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk;
  logic       ResetN;
  logic [3:0] Data;
  logic       WrReq, RdReq;
  logic [3:0] Q;
  logic       QValid, ParityErr, Empty, Full, Overflow, Underflow;
  logic [3:0] RamData, RamWrAddress, RamRdAddress;
  logic       RamWrEn, RamRdEn;
  logic [0:0] RamEDI;
  logic [3:0] RamQ;
  logic [0:0] RamEDO;
  logic       inj;

  int n_cmp = 0;
  int n_bad = 0;

  dp_fifo_ctrl dut (
    .Clock(clk), .ResetN(ResetN), .Data(Data), .WrReq(WrReq), .RdReq(RdReq),
    .Q(Q), .QValid(QValid), .ParityErr(ParityErr), .Empty(Empty), .Full(Full),
    .Overflow(Overflow), .Underflow(Underflow), .RamData(RamData),
    .RamWrAddress(RamWrAddress), .RamRdAddress(RamRdAddress),
    .RamWrEn(RamWrEn), .RamRdEn(RamRdEn), .RamEDI(RamEDI),
    .RamQ(RamQ), .RamEDO(RamEDO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read; inj flips the stored parity.
  logic [3:0] mem [16];
  logic       pmem [16];
  always_ff @(posedge clk) begin
    if (RamWrEn) begin
      mem[RamWrAddress]  <= RamData;
      pmem[RamWrAddress] <= RamEDI[0];
    end
    if (RamRdEn) begin
      RamQ   <= mem[RamRdAddress];
      RamEDO <= pmem[RamRdAddress] ^ inj;
    end
  end

  task automatic test_reset();
    ResetN = 1'b0; WrReq = 1'b0; RdReq = 1'b0; Data = 4'h0; inj = 1'b0;
    repeat (2) @(negedge clk);
    ResetN = 1'b1;
    @(negedge clk);
    n_cmp++; if (Empty !== 1'b1)     begin n_bad++; $display("FAIL reset_empty: got %b exp 1", Empty); end
    n_cmp++; if (Full !== 1'b0)      begin n_bad++; $display("FAIL reset_full: got %b exp 0", Full); end
    n_cmp++; if (QValid !== 1'b0)    begin n_bad++; $display("FAIL reset_qvalid: got %b exp 0", QValid); end
    n_cmp++; if (ParityErr !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b exp 0", ParityErr); end
    n_cmp++; if (Overflow !== 1'b0)  begin n_bad++; $display("FAIL reset_ovf: got %b exp 0", Overflow); end
    n_cmp++; if (Underflow !== 1'b0) begin n_bad++; $display("FAIL reset_udf: got %b exp 0", Underflow); end
    n_cmp++; if (RamWrEn !== 1'b0)   begin n_bad++; $display("FAIL reset_wren: got %b exp 0", RamWrEn); end
    n_cmp++; if (RamRdEn !== 1'b0)   begin n_bad++; $display("FAIL reset_rden: got %b exp 0", RamRdEn); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        n_cmp++; if (Full !== 1'b0) begin n_bad++; $display("FAIL fill_full_early: got %b exp 0", Full); end
      end
      WrReq = 1'b1; Data = 4'(i + 1);
      #1;
      n_cmp++; if (RamWrEn !== 1'b1) begin n_bad++; $display("FAIL fill_wren[%0d]: got %b exp 1", i, RamWrEn); end
      n_cmp++; if (RamWrAddress !== 4'(i)) begin n_bad++; $display("FAIL fill_wraddr[%0d]: got %h exp %h", i, RamWrAddress, 4'(i)); end
    end
    @(negedge clk);
    Data = 4'hE;
    n_cmp++; if (Full !== 1'b1)  begin n_bad++; $display("FAIL fill_full: got %b exp 1", Full); end
    n_cmp++; if (Empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty: got %b exp 0", Empty); end
    #1;
    n_cmp++; if (RamWrEn !== 1'b0) begin n_bad++; $display("FAIL ovf_wren: got %b exp 0", RamWrEn); end
    @(negedge clk);
    WrReq = 1'b0;
    n_cmp++; if (Overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b exp 1", Overflow); end
    n_cmp++; if (Full !== 1'b1)     begin n_bad++; $display("FAIL ovf_full_hold: got %b exp 1", Full); end
    @(negedge clk);
    n_cmp++; if (Overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b exp 0", Overflow); end
  endtask

  task automatic test_drain();
    logic [3:0] exp_q;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k > 0) begin
        exp_q = 4'(k);
        n_cmp++; if (QValid !== 1'b1)    begin n_bad++; $display("FAIL drain_qvalid[%0d]: got %b exp 1", k - 1, QValid); end
        n_cmp++; if (Q !== exp_q)        begin n_bad++; $display("FAIL drain_q[%0d]: got %h exp %h", k - 1, Q, exp_q); end
        n_cmp++; if (ParityErr !== 1'b0) begin n_bad++; $display("FAIL drain_perr[%0d]: got %b exp 0", k - 1, ParityErr); end
      end
      if (k < 16) begin
        RdReq = 1'b1;
        #1;
        n_cmp++; if (RamRdEn !== 1'b1) begin n_bad++; $display("FAIL drain_rden[%0d]: got %b exp 1", k, RamRdEn); end
        n_cmp++; if (RamRdAddress !== 4'(k)) begin n_bad++; $display("FAIL drain_rdaddr[%0d]: got %h exp %h", k, RamRdAddress, 4'(k)); end
      end else begin
        RdReq = 1'b0;
        n_cmp++; if (Empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b exp 1", Empty); end
      end
    end
    @(negedge clk);
    n_cmp++; if (QValid !== 1'b0) begin n_bad++; $display("FAIL drain_qvalid_end: got %b exp 0", QValid); end
  endtask

  task automatic test_simul();
    @(negedge clk);
    WrReq = 1'b1; Data = 4'h7;
    #1;
    n_cmp++; if (RamWrAddress !== 4'h0) begin n_bad++; $display("FAIL sim_wraddr0: got %h exp 0", RamWrAddress); end
    n_cmp++; if (RamEDI !== 1'(PAR_ON)) begin n_bad++; $display("FAIL sim_edi: got %b exp %b", RamEDI, PAR_ON); end
    @(negedge clk);
    RdReq = 1'b1; Data = 4'hA;
    n_cmp++; if (Empty !== 1'b0) begin n_bad++; $display("FAIL sim_empty_pre: got %b exp 0", Empty); end
    #1;
    n_cmp++; if ({RamWrEn, RamRdEn} !== 2'b11) begin n_bad++; $display("FAIL sim_both_en: got %b exp 11", {RamWrEn, RamRdEn}); end
    n_cmp++; if ({RamWrAddress, RamRdAddress} !== 8'h10) begin n_bad++; $display("FAIL sim_addrs: got %h exp 10", {RamWrAddress, RamRdAddress}); end
    @(negedge clk);
    WrReq = 1'b0; RdReq = 1'b0;
    n_cmp++; if (QValid !== 1'b1) begin n_bad++; $display("FAIL sim_qvalid: got %b exp 1", QValid); end
    n_cmp++; if (Q !== 4'h7)      begin n_bad++; $display("FAIL sim_q_old: got %h exp 7", Q); end
    n_cmp++; if (Empty !== 1'b0)  begin n_bad++; $display("FAIL sim_count_kept: got %b exp 0", Empty); end
    @(negedge clk);
    RdReq = 1'b1;
    #1;
    n_cmp++; if (RamRdAddress !== 4'h1) begin n_bad++; $display("FAIL sim_rdaddr1: got %h exp 1", RamRdAddress); end
    @(negedge clk);
    RdReq = 1'b0;
    n_cmp++; if (Q !== 4'hA)     begin n_bad++; $display("FAIL sim_q_new: got %h exp a", Q); end
    n_cmp++; if (Empty !== 1'b1) begin n_bad++; $display("FAIL sim_empty_post: got %b exp 1", Empty); end
    @(negedge clk);
    n_cmp++; if (QValid !== 1'b0) begin n_bad++; $display("FAIL sim_qvalid_end: got %b exp 0", QValid); end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    RdReq = 1'b1;
    #1;
    n_cmp++; if (RamRdEn !== 1'b0) begin n_bad++; $display("FAIL udf_rden: got %b exp 0", RamRdEn); end
    @(negedge clk);
    RdReq = 1'b0;
    n_cmp++; if (Underflow !== 1'b1) begin n_bad++; $display("FAIL udf_pulse: got %b exp 1", Underflow); end
    n_cmp++; if (QValid !== 1'b0)    begin n_bad++; $display("FAIL udf_qvalid: got %b exp 0", QValid); end
    @(negedge clk);
    n_cmp++; if (Underflow !== 1'b0) begin n_bad++; $display("FAIL udf_clear: got %b exp 0", Underflow); end
  endtask

  task automatic test_parity();
    @(negedge clk);
    WrReq = 1'b1; Data = 4'h3;
    #1;
    n_cmp++; if (RamWrAddress !== 4'h2) begin n_bad++; $display("FAIL par_wraddr: got %h exp 2", RamWrAddress); end
    n_cmp++; if (RamEDI !== 1'b0)       begin n_bad++; $display("FAIL par_edi: got %b exp 0", RamEDI); end
    @(negedge clk);
    WrReq = 1'b0; RdReq = 1'b1; inj = 1'b1;
    #1;
    n_cmp++; if (RamRdAddress !== 4'h2) begin n_bad++; $display("FAIL par_rdaddr: got %h exp 2", RamRdAddress); end
    @(negedge clk);
    RdReq = 1'b0; inj = 1'b0;
    n_cmp++; if (QValid !== 1'b1) begin n_bad++; $display("FAIL par_qvalid: got %b exp 1", QValid); end
    n_cmp++; if (Q !== 4'h3)      begin n_bad++; $display("FAIL par_q: got %h exp 3", Q); end
    n_cmp++; if (ParityErr !== PAR_ON) begin n_bad++; $display("FAIL par_err: got %b exp %b", ParityErr, PAR_ON); end
    @(negedge clk);
    n_cmp++; if (ParityErr !== 1'b0) begin n_bad++; $display("FAIL par_err_clear: got %b exp 0", ParityErr); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      WrReq = 1'b1; Data = 4'(i + 1);
    end
    @(negedge clk);
    WrReq = 1'b0; RdReq = 1'b1;
    @(posedge clk);
    #2;
    n_cmp++; if (QValid !== 1'b1) begin n_bad++; $display("FAIL rmid_inflight: got %b exp 1", QValid); end
    ResetN = 1'b0;
    #1;
    n_cmp++; if (QValid !== 1'b0)  begin n_bad++; $display("FAIL rmid_qvalid: got %b exp 0", QValid); end
    n_cmp++; if (Empty !== 1'b1)   begin n_bad++; $display("FAIL rmid_empty: got %b exp 1", Empty); end
    n_cmp++; if (RamRdEn !== 1'b0) begin n_bad++; $display("FAIL rmid_rden: got %b exp 0", RamRdEn); end
    @(negedge clk);
    RdReq = 1'b0; ResetN = 1'b1;
    @(negedge clk);
    WrReq = 1'b1; Data = 4'h5;
    #1;
    n_cmp++; if (RamWrAddress !== 4'h0) begin n_bad++; $display("FAIL rmid_wraddr: got %h exp 0", RamWrAddress); end
    @(negedge clk);
    WrReq = 1'b0; RdReq = 1'b1;
    #1;
    n_cmp++; if (RamRdAddress !== 4'h0) begin n_bad++; $display("FAIL rmid_rdaddr: got %h exp 0", RamRdAddress); end
    @(negedge clk);
    RdReq = 1'b0;
    n_cmp++; if (QValid !== 1'b1) begin n_bad++; $display("FAIL rmid_qvalid_new: got %b exp 1", QValid); end
    n_cmp++; if (Q !== 4'h5)      begin n_bad++; $display("FAIL rmid_q: got %h exp 5", Q); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_underflow();
    test_parity();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_fifo_ctrl.md
# dp_fifo_ctrl

Single-clock FIFO controller that drives the write and read ports of the 16x4 dual-port EBR RAM. It turns a push/pop request interface into RAM address and enable strobes. It generates even parity on the RAM's EDI lane on write and checks parity from the EDO lane on read. The block sits directly upstream of the RAM; both RAM clocks (RdClock, WrClock) are tied to this block's Clock.

## Interface
- lpm_width, 4, data word width; matches the RAM.
- lpm_widthad, 4, address width; depth = 2**lpm_widthad = 16.
- lpm_parity_width, 1, parity lane width; matches the RAM's EDI/EDO.
- Clock  in  1  single clock for the block and both RAM ports.
- ResetN  in  1  asynchronous, active-low reset.
- Data  in  lpm_width  push data.
- WrReq  in  1  push request.
- RdReq  in  1  pop request.
- Q  out  lpm_width  pop data; valid while QValid is high.
- QValid  out  1  Q valid strobe, one cycle per accepted pop.
- ParityErr  out  1  parity mismatch on the word currently presented with QValid.
- Empty / Full  out  1  occupancy flags.
- Overflow / Underflow  out  1  one-cycle pulse on a rejected push / pop.
- RamData  out  lpm_width  to RAM Data.
- RamWrAddress / RamRdAddress  out  lpm_widthad  to RAM WrAddress / RdAddress.
- RamWrEn / RamRdEn  out  1  to RAM WrEn / RdEn.
- RamEDI  out  lpm_parity_width  to RAM EDI.
- RamQ  in  lpm_width  from RAM Q.
- RamEDO  in  lpm_parity_width  from RAM EDO.

## Operation
- State: wr_ptr and rd_ptr (lpm_widthad bits, natural wrap from 15 to 0), count (lpm_widthad+1 bits, range 0..16), and rd_pend (1 bit).
- Push accept: WrReq & !Full.
  - RamWrEn = accept (combinational); RamWrAddress = wr_ptr; RamData = Data.
  - RamEDI = ^Data (even parity) on bit 0; upper parity bits are 0.
  - wr_ptr increments at the clock edge.
- Pop accept: RdReq & !Empty.
  - RamRdEn = accept; RamRdAddress = rd_ptr.
  - rd_ptr increments; rd_pend is set to the accept value each cycle.
- count update: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Flags: Empty = (count==0); Full = (count==16). Both are registered-state decodes with no look-ahead.
- Simultaneous push and pop:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: push accepted, pop rejected (Underflow pulses).
  - Full: pop accepted, push rejected (Overflow pulses); no pass-through.
- Read-during-write to the same address cannot occur. An accepted pop requires count>0, and an accepted push requires count<16, so rd_ptr and wr_ptr never collide on a simultaneous accepted push and pop.
- Q = RamQ, QValid = rd_pend, ParityErr = rd_pend & (^RamQ != RamEDO[0]).

## Timing
- Reset (ResetN low, asynchronous): pointers=0, count=0, rd_pend=0.
  - Outputs: Empty=1, Full=0, QValid=0, ParityErr=0, Overflow=0, Underflow=0, RamWrEn=0, RamRdEn=0.
- Reset asserted mid-operation discards all contents. Any in-flight read's QValid is suppressed immediately.
- Push latency: the word is readable by a pop issued on the cycle after the push edge (Empty falls on that edge).
- Pop latency: accept at edge N, then Q/QValid/ParityErr valid during cycle N+1. This matches the RAM's registered output.
- Back-to-back pops at one per cycle give continuous QValid.
- Overflow/Underflow are registered; each pulses for the cycle after the rejected request.
- Full rises on the edge completing the 16th push; Empty rises on the edge accepting the last pop.

## Configuration
- DP_FIFO_PARITY_EN defined: parity generation and checking as described.
- DP_FIFO_PARITY_EN undefined: RamEDI is driven 0, RamEDO is ignored, and ParityErr is tied 0. All other behaviour is identical.

## Test plan
- Reset, then idle: Empty=1, Full=0, QValid=0, all RAM enables 0.
- Push 0x1..0x10 (low 4 bits) over 16 cycles: Full=1 after the 16th push; a 17th push pulses Overflow and RamWrEn stays 0. Pop 16: Q sequence 0x1..0xF, 0x0, each one cycle after its pop.
- With 1 entry stored, push 0xA and pop on the same cycle: Q = the old word, count stays 1, rd_ptr and wr_ptr both advance.
- Pop while Empty: Underflow=1 for one cycle; RamRdEn=0, no QValid.
- Force RamEDO inverted on a read of 0x3: ParityErr=1 coincident with QValid. With the macro undefined, ParityErr stays 0.
- Pulse ResetN low mid-stream with 5 entries held and a pop in flight: Empty=1 and QValid=0 immediately; a new push/pop of 0x5 returns 0x5.
